// File: rtl/batchnorm_forward_if.sv
// Batch-normalization bus: sample batch, scale/shift,
// capture/consume handshake and registered results.
interface batchnorm_forward_if #(
  parameter int W    = 20,
  parameter int SIZE = 16
);
  logic signed [W-1:0] batch [SIZE];
  logic        [4:0]   num;
  logic signed [W-1:0] gamma;
  logic signed [W-1:0] beta;
  logic                input_ready;
  logic                output_taken;
  logic signed [W-1:0] out  [SIZE];
  logic signed [W-1:0] norm [SIZE];
  logic signed [W-1:0] mu;
  logic signed [W-1:0] vari;
  logic        [1:0]   state;
  logic                done;

  modport master (
    output batch, num, gamma, beta,
    output input_ready, output_taken,
    input  out, norm, mu, vari,
    input  state, done
  );

  modport slave (
    input  batch, num, gamma, beta,
    input  input_ready, output_taken,
    output out, norm, mu, vari,
    output state, done
  );
endinterface

// File: rtl/batchnorm_forward.sv
// Sequential fixed-point batch normalization:
// mean, variance, bitwise sqrt, reciprocal, normalize.
module batchnorm_forward #(
  parameter int IL   = 4,
  parameter int FL   = 16,
  parameter int size = 16
) (
  input  logic               clk,
  input  logic               reset,
  batchnorm_forward_if.slave bus
);
  localparam int W  = IL + FL;
  localparam int AW = (size > 1) ? $clog2(size) : 1;
  localparam int SW = W + 5;
  localparam int PW = 2 * W + 2;
  localparam int QW = 2 * FL + 1;
  localparam logic [W-1:0] MAXP = {1'b0, {(W-1){1'b1}}};
  localparam logic [W-1:0] MINN = {1'b1, {(W-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    DONE = 2'b10
  } state_e;

  typedef enum logic [2:0] {
    P_MEAN, P_VAR, P_SQRT, P_INV, P_NORM
  } phase_e;

  state_e              state_q;
  phase_e              phase_q;
  logic                done_q;
  logic        [4:0]   cnt_q;
  logic        [4:0]   n_q;
  logic signed [W-1:0] x_q [size];
  logic signed [W-1:0] gamma_q;
  logic signed [W-1:0] beta_q;
  logic signed [SW-1:0] sum_q;
  logic        [31:0]  vsum_q;
  logic        [W-1:0] root_q;
  logic        [W-1:0] inv_q;
  logic signed [W-1:0] mu_q;
  logic signed [W-1:0] vari_q;
  logic signed [W-1:0] norm_q [size];
  logic signed [W-1:0] out_q  [size];

  logic        [4:0]    n_d;
  logic        [AW-1:0] idx;
  logic                 last;
  logic signed [W:0]    dif;
  logic signed [SW-1:0] sum_d;
  logic signed [W-1:0]  mu_d;
  logic signed [PW-1:0] sq;
  logic        [31:0]   vsum_d;
  logic        [31:0]   vdiv;
  logic signed [W-1:0]  vari_d;
  logic        [2*W-1:0] rad;
  logic        [4:0]    bitpos;
  logic        [W-1:0]  trial;
  logic        [2*W-1:0] trial_sq;
  logic        [W-1:0]  root_d;
  logic        [QW-1:0] quo;
  logic        [W-1:0]  inv_d;
  logic signed [PW-1:0] np;
  logic signed [W-1:0]  norm_d;
  logic signed [PW-1:0] op;
  logic signed [W-1:0]  out_d;

  function automatic logic [W-1:0] sat(
    input logic signed [PW-1:0] v
  );
    logic [PW-W:0] top;
    top = v[PW-1:W-1];
    if (&top || ~|top) sat = v[W-1:0];
    else sat = v[PW-1] ? MINN : MAXP;
  endfunction

  assign n_d  = (bus.num > 5'(size)) ? 5'(size) : bus.num;
  assign idx  = cnt_q[AW-1:0];
  assign last = (cnt_q == n_q - 5'd1);
  assign dif  = {x_q[idx][W-1], x_q[idx]}
              - {mu_q[W-1], mu_q};

  always_comb begin
    sum_d  = sum_q + {{(SW-W){x_q[idx][W-1]}}, x_q[idx]};
    mu_d   = W'(sum_d / $signed({{(SW-5){1'b0}}, n_q}));
    sq     = PW'(dif) * PW'(dif);
    vsum_d = vsum_q + 32'(sq >>> FL);
    vdiv   = vsum_d / {27'b0, n_q};
    vari_d = (vdiv > 32'(MAXP)) ? MAXP : vdiv[W-1:0];
    // radicand (vari+1)<<FL, root grown one bit per cycle
    rad    = {{(W-1){1'b0}}, {1'b0, vari_q} + (W+1)'(1)} << FL;
    bitpos = 5'(W-1) - cnt_q;
    trial  = root_q | (W'(1) << bitpos);
    trial_sq = (2*W)'(trial) * (2*W)'(trial);
    root_d = (trial_sq <= rad) ? trial : root_q;
    quo    = (QW'(1) << (2*FL)) / QW'(root_q);
    inv_d  = (quo > QW'(MAXP)) ? MAXP : quo[W-1:0];
    np     = PW'(dif) * PW'($signed({1'b0, inv_q}));
    norm_d = sat(np >>> FL);
    op     = PW'(norm_d) * PW'(gamma_q);
    out_d  = sat((op >>> FL) + PW'(beta_q));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      phase_q <= P_MEAN;
      done_q  <= 1'b0;
      cnt_q   <= '0;
      n_q     <= '0;
      gamma_q <= '0;
      beta_q  <= '0;
      sum_q   <= '0;
      vsum_q  <= '0;
      root_q  <= '0;
      inv_q   <= '0;
      mu_q    <= '0;
      vari_q  <= '0;
      for (int i = 0; i < size; i++) begin
        x_q[i]    <= '0;
        norm_q[i] <= '0;
        out_q[i]  <= '0;
      end
    end else begin
      unique case (state_q)
        IDLE: if (bus.input_ready) begin
          state_q <= BUSY;
          phase_q <= (n_d == 5'd0) ? P_SQRT : P_MEAN;
          cnt_q   <= '0;
          n_q     <= n_d;
          x_q     <= bus.batch;
          gamma_q <= bus.gamma;
          beta_q  <= bus.beta;
          sum_q   <= '0;
          vsum_q  <= '0;
          root_q  <= '0;
          inv_q   <= '0;
          mu_q    <= '0;
          vari_q  <= '0;
          for (int i = 0; i < size; i++) begin
            norm_q[i] <= '0;
            out_q[i]  <= '0;
          end
        end
        BUSY: begin
          unique case (phase_q)
            P_MEAN: begin
              sum_q <= sum_d;
              cnt_q <= last ? 5'd0 : cnt_q + 5'd1;
              if (last) begin
                mu_q    <= mu_d;
                phase_q <= P_VAR;
              end
            end
            P_VAR: begin
              vsum_q <= vsum_d;
              cnt_q  <= last ? 5'd0 : cnt_q + 5'd1;
              if (last) begin
                vari_q  <= vari_d;
                phase_q <= P_SQRT;
              end
            end
            P_SQRT: begin
              root_q <= root_d;
              if (cnt_q == 5'(W-1)) begin
                cnt_q   <= '0;
                phase_q <= P_INV;
              end else begin
                cnt_q <= cnt_q + 5'd1;
              end
            end
            P_INV: begin
              inv_q   <= inv_d;
              phase_q <= P_NORM;
              if (n_q == 5'd0) begin
                state_q <= DONE;
                done_q  <= 1'b1;
              end
            end
            P_NORM: begin
              norm_q[idx] <= norm_d;
              out_q[idx]  <= out_d;
              cnt_q <= last ? 5'd0 : cnt_q + 5'd1;
              if (last) begin
                state_q <= DONE;
                done_q  <= 1'b1;
              end
            end
            default: state_q <= IDLE;
          endcase
        end
        DONE: if (bus.output_taken) begin
          state_q <= IDLE;
          done_q  <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.out   = out_q;
  assign bus.norm  = norm_q;
  assign bus.mu    = mu_q;
  assign bus.vari  = vari_q;
  assign bus.state = state_q;
  assign bus.done  = done_q;
endmodule

// File: tb/tb_batchnorm_forward.sv
// Randomized and directed bench for batchnorm_forward
// against a plain-arithmetic reference model.
module tb_batchnorm_forward;
  localparam int W = 20;
  localparam int N = 16;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  batchnorm_forward_if #(.W(W), .SIZE(N)) bus ();

  batchnorm_forward #(.IL(4), .FL(16), .size(N)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  longint xv [N];
  int     num_v;
  longint g_v, b_v;
  longint mu_m, vari_m;
  int     n_m;
  logic [W-1:0] norm_m [N];
  logic [W-1:0] out_m  [N];

  function automatic longint sat20(input longint v);
    if (v > 524287) return 524287;
    if (v < -524288) return -524288;
    return v;
  endfunction

  task automatic model_compute();
    longint s, d, vs, rad, r, inv, t;
    n_m = (num_v > N) ? N : num_v;
    s = 0;
    for (int i = 0; i < n_m; i++) s += xv[i];
    mu_m = (n_m == 0) ? 0 : s / n_m;
    vs = 0;
    for (int i = 0; i < n_m; i++) begin
      d = xv[i] - mu_m;
      vs += (d * d) >>> 16;
    end
    vari_m = (n_m == 0) ? 0 : vs / n_m;
    if (vari_m > 64'h7FFFF) vari_m = 64'h7FFFF;
    rad = (vari_m + 1) << 16;
    r = longint'($sqrt(real'(rad)));
    while (r * r > rad) r--;
    while ((r + 1) * (r + 1) <= rad) r++;
    inv = (longint'(1) << 32) / r;
    if (inv > 64'h7FFFF) inv = 64'h7FFFF;
    for (int i = 0; i < N; i++) begin
      if (i < n_m) begin
        d = xv[i] - mu_m;
        t = sat20((d * inv) >>> 16);
        norm_m[i] = W'(t);
        out_m[i]  = W'(sat20(((t * g_v) >>> 16) + b_v));
      end else begin
        norm_m[i] = '0;
        out_m[i]  = '0;
      end
    end
  endtask

  task automatic apply_inputs();
    for (int i = 0; i < N; i++) bus.batch[i] = W'(xv[i]);
    bus.num   = 5'(num_v);
    bus.gamma = W'(g_v);
    bus.beta  = W'(b_v);
  endtask

  task automatic rand_stim(input int nsel);
    int k;
    k = $urandom_range(12, 19);
    for (int i = 0; i < N; i++)
      xv[i] = longint'($urandom_range(0, (1 << (k + 1)) - 1))
            - (longint'(1) << k);
    num_v = nsel;
    g_v = longint'($urandom_range(0, 20'hFFFFF)) - 524288;
    b_v = longint'($urandom_range(0, 20'hFFFFF)) - 524288;
  endtask

  task automatic spec_stim();
    for (int i = 0; i < N; i++)
      xv[i] = longint'($urandom_range(0, 20'hFFFFF));
    xv[0] = 0; xv[1] = 'h20000;
    xv[2] = 0; xv[3] = 'h20000;
    num_v = 4; g_v = 'h20000; b_v = 'h08000;
  endtask

  // returns edges from capture until done is seen (200 = timeout)
  task automatic run_batch(output int lat);
    @(negedge clk);
    apply_inputs();
    bus.input_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.input_ready = 1'b0;
    lat = 0;
    while (lat < 200) begin
      @(posedge clk);
      lat++;
      #1;
      if (bus.done) break;
    end
  endtask

  task automatic take_output();
    @(negedge clk);
    bus.output_taken = 1'b1;
    @(negedge clk);
    bus.output_taken = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (bus.state !== 2'b00 || bus.done !== 1'b0) begin
      errors++;
      $display("FAIL reset_state got %b/%b exp 00/0",
               bus.state, bus.done);
    end
    checks++;
    if (bus.mu !== '0 || bus.vari !== '0) begin
      errors++;
      $display("FAIL reset_mu_vari got %h/%h exp 0/0",
               bus.mu, bus.vari);
    end
    for (int i = 0; i < N; i++) begin
      checks++;
      if (bus.norm[i] !== '0 || bus.out[i] !== '0) begin
        errors++;
        $display("FAIL reset_vec[%0d] got %h/%h exp 0/0",
                 i, bus.norm[i], bus.out[i]);
      end
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_spec_example();
    int lat;
    logic [W-1:0] en [4];
    logic [W-1:0] eo [4];
    en = '{20'hF0000, 20'h10000, 20'hF0000, 20'h10000};
    eo = '{20'hE8000, 20'h28000, 20'hE8000, 20'h28000};
    spec_stim();
    run_batch(lat);
    checks++;
    if (lat !== 33) begin
      errors++;
      $display("FAIL ex_latency got %0d exp 33", lat);
    end
    checks++;
    if (bus.mu !== 20'h10000 || bus.vari !== 20'h10000) begin
      errors++;
      $display("FAIL ex_mu_vari got %h/%h exp 10000/10000",
               bus.mu, bus.vari);
    end
    for (int i = 0; i < N; i++) begin
      checks++;
      if (i < 4) begin
        if (bus.norm[i] !== en[i] || bus.out[i] !== eo[i]) begin
          errors++;
          $display("FAIL ex_vec[%0d] got %h/%h exp %h/%h",
                   i, bus.norm[i], bus.out[i], en[i], eo[i]);
        end
      end else if (bus.norm[i] !== '0 || bus.out[i] !== '0) begin
        errors++;
        $display("FAIL ex_tail[%0d] got %h/%h exp 0/0",
                 i, bus.norm[i], bus.out[i]);
      end
    end
    take_output();
  endtask

  task automatic test_constant();
    int lat;
    for (int i = 0; i < N; i++) xv[i] = 'h10000;
    num_v = 4; g_v = 'h10000; b_v = 0;
    run_batch(lat);
    checks++;
    if (lat !== 33) begin
      errors++;
      $display("FAIL const_latency got %0d exp 33", lat);
    end
    checks++;
    if (bus.mu !== 20'h10000 || bus.vari !== '0) begin
      errors++;
      $display("FAIL const_mu_vari got %h/%h exp 10000/0",
               bus.mu, bus.vari);
    end
    checks++;
    if (dut.root_q !== 20'd256 || dut.inv_q !== 20'h7FFFF) begin
      errors++;
      $display("FAIL const_root_inv got %h/%h exp 100/7ffff",
               dut.root_q, dut.inv_q);
    end
    for (int i = 0; i < N; i++) begin
      checks++;
      if (bus.norm[i] !== '0 || bus.out[i] !== '0) begin
        errors++;
        $display("FAIL const_vec[%0d] got %h/%h exp 0/0",
                 i, bus.norm[i], bus.out[i]);
      end
    end
    take_output();
  endtask

  task automatic test_zero_count();
    int lat;
    rand_stim(0);
    run_batch(lat);
    checks++;
    if (lat !== 21) begin
      errors++;
      $display("FAIL zero_latency got %0d exp 21", lat);
    end
    checks++;
    if (bus.mu !== '0 || bus.vari !== '0) begin
      errors++;
      $display("FAIL zero_mu_vari got %h/%h exp 0/0",
               bus.mu, bus.vari);
    end
    for (int i = 0; i < N; i++) begin
      checks++;
      if (bus.norm[i] !== '0 || bus.out[i] !== '0) begin
        errors++;
        $display("FAIL zero_vec[%0d] got %h/%h exp 0/0",
                 i, bus.norm[i], bus.out[i]);
      end
    end
    take_output();
  endtask

  task automatic test_clamp();
    int lat;
    logic [W-1:0] eb;
    for (int i = 0; i < N; i++) xv[i] = 'h04000;
    num_v = 31;
    g_v = 'h30000;
    b_v = longint'($urandom_range(0, 20'hFFFFF)) - 524288;
    eb = W'(b_v);
    run_batch(lat);
    checks++;
    if (lat !== 69) begin
      errors++;
      $display("FAIL clamp_latency got %0d exp 69", lat);
    end
    checks++;
    if (bus.mu !== 20'h04000 || bus.vari !== '0) begin
      errors++;
      $display("FAIL clamp_mu_vari got %h/%h exp 04000/0",
               bus.mu, bus.vari);
    end
    checks++;
    if (bus.out[0] !== eb || bus.out[15] !== eb) begin
      errors++;
      $display("FAIL clamp_out got %h/%h exp %h",
               bus.out[0], bus.out[15], eb);
    end
    take_output();
  endtask

  task automatic test_reset_mid();
    int lat;
    spec_stim();
    @(negedge clk);
    apply_inputs();
    bus.input_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.input_ready = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    bus.input_ready = 1'b1;
    bus.output_taken = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (bus.state !== 2'b00 || bus.done !== 1'b0) begin
      errors++;
      $display("FAIL midrst_state got %b/%b exp 00/0",
               bus.state, bus.done);
    end
    checks++;
    if (bus.mu !== '0 || bus.vari !== '0 ||
        dut.sum_q !== '0 || dut.vsum_q !== '0 ||
        dut.cnt_q !== '0) begin
      errors++;
      $display("FAIL midrst_regs got mu %h vari %h sum %h vs %h cnt %h exp 0",
               bus.mu, bus.vari, dut.sum_q, dut.vsum_q, dut.cnt_q);
    end
    for (int i = 0; i < N; i++) begin
      checks++;
      if (bus.norm[i] !== '0 || bus.out[i] !== '0) begin
        errors++;
        $display("FAIL midrst_vec[%0d] got %h/%h exp 0/0",
                 i, bus.norm[i], bus.out[i]);
      end
    end
    @(negedge clk);
    reset = 1'b0;
    bus.input_ready = 1'b0;
    bus.output_taken = 1'b0;
    run_batch(lat);
    checks++;
    if (lat !== 33 || bus.mu !== 20'h10000 ||
        bus.out[1] !== 20'h28000) begin
      errors++;
      $display("FAIL midrst_rerun got lat %0d mu %h out1 %h exp 33/10000/28000",
               lat, bus.mu, bus.out[1]);
    end
    take_output();
  endtask

  task automatic test_random();
    int lat;
    for (int t = 0; t < 25; t++) begin
      rand_stim($urandom_range(0, 31));
      model_compute();
      run_batch(lat);
      checks++;
      if (lat !== 3 * n_m + 21) begin
        errors++;
        $display("FAIL rnd%0d_latency got %0d exp %0d",
                 t, lat, 3 * n_m + 21);
      end
      checks++;
      if (bus.mu !== W'(mu_m) || bus.vari !== W'(vari_m)) begin
        errors++;
        $display("FAIL rnd%0d_mu_vari got %h/%h exp %h/%h",
                 t, bus.mu, bus.vari, W'(mu_m), W'(vari_m));
      end
      for (int i = 0; i < N; i++) begin
        checks++;
        if (bus.norm[i] !== norm_m[i] ||
            bus.out[i] !== out_m[i]) begin
          errors++;
          $display("FAIL rnd%0d_vec[%0d] got %h/%h exp %h/%h",
                   t, i, bus.norm[i], bus.out[i],
                   norm_m[i], out_m[i]);
        end
      end
      take_output();
    end
  endtask

  task automatic test_back_to_back();
    int lat;
    logic [1:0] es;
    rand_stim(3);
    model_compute();
    @(negedge clk);
    apply_inputs();
    bus.input_ready = 1'b1;
    @(posedge clk);
    for (int k = 1; k <= 33; k++) begin
      @(posedge clk);
      #1;
      es = (k < 30) ? 2'b01 : 2'b10;
      checks++;
      if (bus.state !== es || bus.done !== es[1]) begin
        errors++;
        $display("FAIL b2b_state@%0d got %b/%b exp %b",
                 k, bus.state, bus.done, es);
      end
    end
    for (int i = 0; i < N; i++) begin
      checks++;
      if (bus.norm[i] !== norm_m[i] ||
          bus.out[i] !== out_m[i]) begin
        errors++;
        $display("FAIL b2b_vec[%0d] got %h/%h exp %h/%h",
                 i, bus.norm[i], bus.out[i], norm_m[i], out_m[i]);
      end
    end
    @(negedge clk);
    bus.output_taken = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (bus.state !== 2'b00) begin
      errors++;
      $display("FAIL b2b_idle got %b exp 00", bus.state);
    end
    @(negedge clk);
    bus.output_taken = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (bus.state !== 2'b01) begin
      errors++;
      $display("FAIL b2b_recapture got %b exp 01", bus.state);
    end
    @(negedge clk);
    bus.input_ready = 1'b0;
    lat = 0;
    while (lat < 200) begin
      @(posedge clk);
      lat++;
      #1;
      if (bus.done) break;
    end
    checks++;
    if (lat !== 30 || bus.mu !== W'(mu_m) ||
        bus.out[2] !== out_m[2]) begin
      errors++;
      $display("FAIL b2b_second got lat %0d mu %h out2 %h exp 30/%h/%h",
               lat, bus.mu, bus.out[2], W'(mu_m), out_m[2]);
    end
    take_output();
  endtask

  initial begin
    reset = 1'b1;
    bus.input_ready  = 1'b0;
    bus.output_taken = 1'b0;
    bus.num   = '0;
    bus.gamma = '0;
    bus.beta  = '0;
    for (int i = 0; i < N; i++) bus.batch[i] = '0;
    test_reset();
    test_spec_example();
    test_constant();
    test_zero_count();
    test_clamp();
    test_reset_mid();
    test_random();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end
endmodule

// File: doc/batchnorm_forward.md
BATCHNORM_FORWARD -- requirements
Module: batchnorm_forward

Interface
REQ-001 SHALL have parameter IL, default 4, integer bits of the signed fixed-point format.
REQ-002 SHALL have parameter FL, default 16, fraction bits; W = IL+FL = 20.
REQ-003 SHALL have parameter size, default 16, maximum batch length.
REQ-004 SHALL have port clk  input  1  sole clock, all state updates on rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port batch  input  signed [W-1:0] x size  input samples x[i].
REQ-007 SHALL have port num  input  5  valid sample count; values above size are clamped to size.
REQ-008 SHALL have port gamma  input  signed W  scale; port beta  input  signed W  shift.
REQ-009 SHALL have port input_ready  input  1  request to accept a new batch.
REQ-010 SHALL have port output_taken  input  1  consumer has read the results.
REQ-011 SHALL have port out  output  signed W x size  gamma*norm+beta per sample.
REQ-012 SHALL have port norm  output  signed W x size  normalized samples.
REQ-013 SHALL have port mu  output  signed W  batch mean; port vari  output  signed W  batch variance.
REQ-014 SHALL have port state  output  2  00 IDLE, 01 BUSY, 10 DONE.
REQ-015 SHALL have port done  output  1  high exactly while state==DONE.

Function
REQ-016 SHALL, in IDLE with input_ready=1, register batch, clamped num (n), gamma and beta and enter BUSY at that edge (E0); input_ready is ignored outside IDLE.
REQ-017 SHALL step BUSY through sub-phases MEAN (n cycles), VAR (n cycles), SQRT (20 cycles), INV (1 cycle), NORM (n cycles), one sample or one root bit per cycle.
REQ-018 SHALL enter DONE at edge E0+3n+21 (n=4: E0+33); n=0 skips MEAN/VAR/NORM and gives E0+21.
REQ-019 MEAN: sum x[i] in a 25-bit signed accumulator; mu = sum/n, signed division truncating toward zero; mu=0 when n=0.
REQ-020 VAR: d[i] = x[i]-mu in 21 bits; accumulate (d*d)>>>FL unsigned in 32 bits; vari = min(sum/n, 0x7FFFF).
REQ-021 SQRT: root = floor(sqrt((vari+1)<<FL)), computed bitwise over 20 cycles, unsigned 20-bit result.
REQ-022 INV: inv_std = (1<<(2*FL))/root, truncating, saturated to 0x7FFFF.
REQ-023 NORM: norm[i] = (d[i]*inv_std)>>>FL; out[i] = ((norm[i]*gamma)>>>FL)+beta; each saturated to signed 20-bit [0x80000,0x7FFFF].
REQ-024 SHALL drive norm[i] and out[i] to 0 for every i>=n.
REQ-025 SHALL hold out, norm, mu, vari stable from DONE entry until the next batch is accepted.
REQ-026 SHALL leave DONE for IDLE on the edge where output_taken=1; output_taken ignored in IDLE/BUSY.
REQ-027 SHALL, when output_taken and input_ready are both high in DONE, go to IDLE only; the new batch is accepted no earlier than the following edge.
REQ-028 >>> denotes arithmetic (floor) shift of the full-width product before saturation.

Reset
REQ-029 SHALL, on any edge with reset=1, including mid-BUSY, force state=IDLE, done=0 and out, norm, mu, vari, all accumulators and the sub-phase counter to 0.
REQ-030 SHALL give reset priority over input_ready and output_taken in the same cycle.

Verification
REQ-031 n=4, x=[0,2.0,0,2.0] (0x00000,0x20000,...), gamma=0x20000, beta=0x08000 -> done at E0+33; mu=0x10000, vari=0x10000, norm=[0xF0000,0x10000,0xF0000,0x10000], out=[0xE8000,0x28000,0xE8000,0x28000], out[4..15]=0.
REQ-032 n=4, all x=0x10000, gamma=0x10000, beta=0 -> mu=0x10000, vari=0, root=256, inv_std saturated 0x7FFFF, norm=0, out=0.
REQ-033 n=0, input_ready pulse -> DONE at E0+21, mu=vari=0, all norm/out=0.
REQ-034 num=31 with 16 samples of 0x04000 -> treated as n=16, DONE at E0+69, mu=0x04000.
REQ-035 reset asserted at E0+10 of REQ-031 run -> next edge state=00, done=0, all outputs 0; new batch then completes normally.
REQ-036 input_ready held high throughout BUSY and DONE, output_taken pulsed in DONE -> no re-capture during BUSY; IDLE one cycle, then next batch accepted.
